// File: rtl/sr04_pkg.sv
// sr04_pkg: constants and types shared by the SR04 controller and its measurement
// scheduler.
// Contents:
//   SR04_DIST_W, SR04_DIST_MAX   distance bus width and clamp ceiling (cm)
//   SR04_GAP_MS, SR04_TIMEOUT_MS inter-shot settling gap and echo timeout (ms)
//   SR04_MS_W                    width of the shared millisecond counter
//   SR04_PTR_W                   width of the round-robin pointer (up to 4 requesters)
//   state_t                      scheduler FSM encoding
//   onehot_to_idx()              one-hot grant to requester index
package sr04_pkg;

  localparam int unsigned SR04_DIST_W     = 9;
  localparam int unsigned SR04_DIST_MAX   = 400;
  localparam int unsigned SR04_GAP_MS     = 60;
  localparam int unsigned SR04_TIMEOUT_MS = 30;
  // Wide enough for whichever of the gap or timeout windows is longer.
  localparam int unsigned SR04_MS_W       = 7;
  localparam int unsigned SR04_PTR_W      = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StGap,
    StReport
  } state_t;

  function automatic logic [SR04_PTR_W-1:0] onehot_to_idx(input logic [3:0] oh);
    logic [SR04_PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = SR04_PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among N_REQ level requests.
// The search starts one past the last served requester, so a requester is only
// picked again after every other pending requester has had a turn.
// Ports:
//   req  in   N_REQ       pending requests
//   ptr  in   SR04_PTR_W  index of the requester served last
//   gnt  out  N_REQ       one-hot pick, all zero when nothing is pending
module rr_arbiter
  import sr04_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0]      req,
  input  logic [SR04_PTR_W-1:0] ptr,
  output logic [N_REQ-1:0]      gnt
);

  always_comb begin
    logic [SR04_PTR_W-1:0] idx;
    gnt = '0;
    idx = '0;
    // Walk from the farthest candidate to the nearest; the nearest pending one wins.
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      idx = SR04_PTR_W'((32'(ptr) + i) % N_REQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr04_meas_sched.sv
// sr04_meas_sched: shares one SR04 sensor among N_REQ requesters. Each grant runs
// 2**AVG_LOG2 trigger/echo shots separated by a settling gap, averages the distances
// and returns one result to the granted requester.
// Ports:
//   iClk       in   1       system clock
//   iRst       in   1       asynchronous reset, active-high
//   imSec      in   1       one-cycle pulse every millisecond
//   iReq       in   N_REQ   level requests, held until the requester's oValid bit
//   oGnt       out  N_REQ   one-hot grant, stable for the whole transaction
//   oStart     out  1       one-cycle start pulse to the SR04 controller
//   iDone      in   1       one-cycle pulse, iDistance valid
//   iErr       in   1       one-cycle pulse, sensor error
//   iDistance  in   DIST_W  measured distance (cm)
//   oDistance  out  DIST_W  averaged result, held between reports
//   oValid     out  N_REQ   one-cycle pulse on the granted requester's bit
//   oErr       out  1       qualifies oValid: transaction aborted, held between reports
module sr04_meas_sched
  import sr04_pkg::*;
#(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned GAP_MS     = SR04_GAP_MS,
  parameter int unsigned TIMEOUT_MS = SR04_TIMEOUT_MS,
  parameter int unsigned DIST_W     = SR04_DIST_W,
  parameter int unsigned DIST_MAX   = SR04_DIST_MAX
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              imSec,
  input  logic [N_REQ-1:0]  iReq,
  output logic [N_REQ-1:0]  oGnt,
  output logic              oStart,
  input  logic              iDone,
  input  logic              iErr,
  input  logic [DIST_W-1:0] iDistance,
  output logic [DIST_W-1:0] oDistance,
  output logic [N_REQ-1:0]  oValid,
  output logic              oErr
);

  // Sum of 2**AVG_LOG2 clamped samples cannot overflow this width.
  localparam int unsigned ACC_W = DIST_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0]     N_SHOTS  = CNT_W'(2 ** AVG_LOG2);
  localparam logic [DIST_W-1:0]    CLAMP    = DIST_W'(DIST_MAX);
  localparam logic [SR04_MS_W-1:0] GAP_LAST = SR04_MS_W'(GAP_MS - 1);
  localparam logic [SR04_MS_W-1:0] TO_LAST  = SR04_MS_W'(TIMEOUT_MS - 1);

  state_t                state;
  logic [SR04_MS_W-1:0]  ms_cnt;
  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      cnt;
  logic [SR04_PTR_W-1:0] ptr;
  logic [N_REQ-1:0]      pick;
  logic [DIST_W-1:0]     clamped;

  assign clamped = (iDistance > CLAMP) ? CLAMP : iDistance;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req (iReq),
    .ptr (ptr),
    .gnt (pick)
  );

  // Outputs are registered so that each pulse is visible during the state it names:
  // oStart while in StStart, oValid while in StReport.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= StIdle;
      ms_cnt    <= '0;
      acc       <= '0;
      cnt       <= '0;
      ptr       <= '0;
      oGnt      <= '0;
      oStart    <= 1'b0;
      oValid    <= '0;
      oErr      <= 1'b0;
      oDistance <= '0;
    end else begin
      oStart <= 1'b0;
      oValid <= '0;
      unique case (state)
        StIdle: begin
          if (|iReq) begin
            oGnt   <= pick;
            acc    <= '0;
            cnt    <= '0;
            oStart <= 1'b1;
            state  <= StStart;
          end
        end
        StStart: begin
          ms_cnt <= '0;
          state  <= StWait;
        end
        StWait: begin
          if (iErr) begin
            oErr   <= 1'b1;
            oValid <= oGnt;
            state  <= StReport;
          end else if (iDone) begin
            acc    <= acc + ACC_W'(clamped);
            cnt    <= cnt + 1'b1;
            ms_cnt <= '0;
            state  <= StGap;
          end else if (imSec) begin
            if (ms_cnt == TO_LAST) begin
              oErr   <= 1'b1;
              oValid <= oGnt;
              state  <= StReport;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        StGap: begin
          if (imSec) begin
            if (ms_cnt == GAP_LAST) begin
              if (cnt == N_SHOTS) begin
                oDistance <= DIST_W'(acc >> AVG_LOG2);
                oErr      <= 1'b0;
                oValid    <= oGnt;
                state     <= StReport;
              end else begin
                oStart <= 1'b1;
                state  <= StStart;
              end
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        StReport: begin
          ptr   <= onehot_to_idx(4'(oGnt));
          oGnt  <= '0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
